grid_readout: RTL and testbench
===============================

// Module: grid_readout
// PURPOSE
//  Downstream consumer of the sudoku solver grid. Once the grid flags done_success,
//  snapshots all tile one-hot values and streams them out one tile per beat, in
//  row-major order, as binary digits over a valid/ready handshake. On done_failure,
//  emits a single failure beat instead. Re-arms only after the grid drops both done flags.
// PARAMETERS
//  GRID_ORD   3   block order; GRID_LEN=GRID_ORD**2, GRID_AREA=GRID_LEN**2 (localparams)
//  DIGIT_W    $clog2(GRID_LEN+1)   out_digit width (4 for ORD=3)
//  IDX_W      $clog2(GRID_AREA)    out_index width (7 for ORD=3)
// PORTS
//  clock         in   1                   sole clock, rising edge
//  reset         in   1                   asynchronous, active-low reset
//  done_success  in   1                   level from grid: solve succeeded
//  done_failure  in   1                   level from grid: solve exhausted
//  values        in   GRID_AREA*GRID_LEN  tile one-hots, row-major; tile i at [i*GRID_LEN+:GRID_LEN]
//  out_valid     out  1                   beat available
//  out_ready     in   1                   consumer accepts beat
//  out_digit     out  DIGIT_W             1..GRID_LEN; 0 = empty/invalid tile or failure beat
//  out_index     out  IDX_W               tile index of the beat (0 on failure beat)
//  out_last      out  1                   final beat of the frame
//  out_fail      out  1                   beat is the failure report
//  busy          out  1                   state != IDLE
//  err           out  1                   sticky one-hot violation (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0): state=IDLE; all outputs 0; snapshot cleared. All outputs registered.
//  States: IDLE -> STREAM | FAIL -> DRAIN -> IDLE.
//  IDLE: done_failure=1 -> FAIL (failure wins if both flags high the same cycle);
//        else done_success=1 -> capture values into snapshot, index=0, STREAM.
//        out_valid rises the cycle after the flag is sampled (1-cycle latency).
//  STREAM: out_digit = encode(snapshot tile[index]); beat transfers when
//        out_valid&&out_ready; index++ on transfer; out_last=1 iff index==GRID_AREA-1.
//        Transfer of last beat -> DRAIN, out_valid=0 next cycle.
//  FAIL: one beat {digit=0,index=0,last=1,fail=1}; on transfer -> DRAIN.
//  DRAIN: wait until done_success==0 && done_failure==0, then IDLE (no re-trigger
//        on stale levels). If already both low, IDLE next cycle.
//  Handshake: once out_valid=1, digit/index/last/fail hold stable until transfer;
//        out_valid never drops without a transfer. out_ready ignored when out_valid=0.
//        Back-to-back beats at 1/cycle when out_ready held high.
//  Encode: lowest set bit b -> digit b+1; all-zero -> 0.
//  Snapshot insulates stream from values/done changes after capture.
//  err: cleared only by reset.
//  Reset mid-frame: immediate abort, outputs 0, IDLE; no partial-frame resume.
// CONFIGURATION
//  GRID_READOUT_ONEHOT_CHECK_EN defined: each streamed tile checked; tile with 0 or
//   >1 bits set emits digit 0 and sets err (sticky) on that beat's transfer.
//  Undefined: no check; err tied 0; encode as above (lowest set bit).
// TESTING
//  1 Known 9x9 solution, done_success pulse, out_ready=1 -> 81 beats in 81 consecutive
//    cycles starting 1 cycle after flag; beat 0 digit = tile0 value; beat 80 last=1.
//  2 Same grid, out_ready random 30% -> identical 81-beat sequence, data stable while stalled.
//  3 done_failure=1 -> single beat digit=0,index=0,last=1,fail=1; busy until flags low.
//  4 done_success&done_failure same cycle -> failure beat only; flags held high after
//    frame -> no second frame until both drop and reassert.
//  5 reset low at beat 40 of stream -> outputs 0 same cycle (async), IDLE; new done -> fresh frame from index 0.
//  6 (_EN defined) tile 17 = 9'b000000101 -> beat 17 digit=0, err=1 stays set;
//    (undefined) same stimulus -> digit=1, err=0.

Source files
------------

// File: rtl/grid_readout.sv
// grid_readout: streams a captured sudoku grid as one digit per beat over valid/ready (optional GRID_READOUT_ONEHOT_CHECK_EN)
module grid_readout #(
  parameter int GRID_ORD = 3,
  parameter int DIGIT_W  = $clog2(GRID_ORD**2 + 1),
  parameter int IDX_W    = $clog2(GRID_ORD**4)
) (
  input  logic                                clock_i,
  input  logic                                reset_ni,
  input  logic                                done_success_i,
  input  logic                                done_failure_i,
  input  logic [GRID_ORD**4*GRID_ORD**2-1:0]  values_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [DIGIT_W-1:0]                  out_digit_o,
  output logic [IDX_W-1:0]                    out_index_o,
  output logic                                out_last_o,
  output logic                                out_fail_o,
  output logic                                busy_o,
  output logic                                err_o
);
  localparam int GRID_LEN  = GRID_ORD**2;
  localparam int GRID_AREA = GRID_LEN**2;
  localparam int VAL_W     = GRID_AREA*GRID_LEN;
  typedef enum logic [1:0] {IDLE, STREAM, FAIL, DRAIN} state_e;
  state_e               state_q, state_d;
  logic [VAL_W-1:0]     snap_q, snap_d;
  logic [IDX_W-1:0]     idx_q, idx_d, nxt;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic                 valid_q, valid_d, last_q, last_d, fail_q, fail_d, busy_q;
  logic                 xfer;
  assign xfer = valid_q && out_ready_i;
  assign nxt  = idx_q + IDX_W'(1);
  // Lowest set bit wins; with the check enabled a non-one-hot tile reads as empty.
  function automatic logic [DIGIT_W-1:0] enc(input logic [GRID_LEN-1:0] t);
    enc = '0;
    for (int b = GRID_LEN - 1; b >= 0; b--)
      if (t[b]) enc = DIGIT_W'(b + 1);
`ifdef GRID_READOUT_ONEHOT_CHECK_EN
    if (!$onehot(t)) enc = '0;
`endif
  endfunction
  // Next state and next registered beat; beat fields only change on entry or on transfer.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    digit_d = digit_q;
    valid_d = valid_q;
    last_d  = last_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (done_failure_i) begin
          state_d = FAIL;
          idx_d   = '0;
          digit_d = '0;
          valid_d = 1'b1;
          last_d  = 1'b1;
          fail_d  = 1'b1;
        end else if (done_success_i) begin
          state_d = STREAM;
          snap_d  = values_i;
          idx_d   = '0;
          digit_d = enc(values_i[GRID_LEN-1:0]);
          valid_d = 1'b1;
          last_d  = GRID_AREA == 1;
          fail_d  = 1'b0;
        end
      end
      STREAM: begin
        if (xfer && last_q) begin
          state_d = DRAIN;
          idx_d   = '0;
          digit_d = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (xfer) begin
          idx_d   = nxt;
          digit_d = enc(snap_q[int'(nxt)*GRID_LEN +: GRID_LEN]);
          last_d  = nxt == IDX_W'(GRID_AREA - 1);
        end
      end
      FAIL: begin
        if (xfer) begin
          state_d = DRAIN;
          valid_d = 1'b0;
          last_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      DRAIN: state_d = (!done_success_i && !done_failure_i) ? IDLE : DRAIN;
    endcase
  end
  // State, snapshot and output registers; reset aborts any frame in flight.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fail_q  <= fail_d;
      busy_q  <= state_d != IDLE;
    end
  end
`ifdef GRID_READOUT_ONEHOT_CHECK_EN
  logic                err_q;
  logic [GRID_LEN-1:0] cur;
  assign cur = snap_q[int'(idx_q)*GRID_LEN +: GRID_LEN];
  // Sticky violation flag, raised when a malformed tile's beat is accepted.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) err_q <= 1'b0;
    else if (xfer && state_q == STREAM && !$onehot(cur)) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
  assign out_valid_o = valid_q;
  assign out_digit_o = digit_q;
  assign out_index_o = idx_q;
  assign out_last_o  = last_q;
  assign out_fail_o  = fail_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_grid_readout.sv
// tb_grid_readout: scoreboard bench for grid_readout
module tb_grid_readout;
  localparam int LEN  = 9;
  localparam int AREA = 81;
  logic             clock = 1'b0;
  logic             reset_n;
  logic             done_success, done_failure, out_ready;
  logic [AREA*LEN-1:0] values;
  logic             out_valid, out_last, out_fail, busy, err;
  logic [3:0]       out_digit;
  logic [6:0]       out_index;
  logic [13:0]      q[$];
  logic [13:0]      prev, cur;
  logic [3:0]       expd[AREA];
  logic             stall_prev = 1'b0;
  logic             rnd = 1'b0;
  int               vectors = 0;
  int               miscompares = 0;

  grid_readout dut (
    .clock_i(clock), .reset_ni(reset_n), .done_success_i(done_success),
    .done_failure_i(done_failure), .values_i(values), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_digit_o(out_digit), .out_index_o(out_index),
    .out_last_o(out_last), .out_fail_o(out_fail), .busy_o(busy), .err_o(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (rnd) out_ready = $urandom_range(0, 99) < 30;
  endtask

  task automatic load_sol();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        expd[r*9+c] = 4'(((r*3 + r/3 + c) % 9) + 1);
        values[(r*9+c)*LEN +: LEN] = 9'(1) << (expd[r*9+c] - 1);
      end
  endtask

  task automatic push_frame();
    for (int i = 0; i < AREA; i++) q.push_back({1'b1, expd[i], 7'(i), i == AREA - 1, 1'b0});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  // Monitor: pops and compares accepted beats, and checks stalled beats hold.
  always @(negedge clock) begin
    cur = {out_valid, out_digit, out_index, out_last, out_fail};
    if (!reset_n) stall_prev = 1'b0;
    else begin
      if (stall_prev) chk("hold", cur, prev);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", out_valid, 0);
        else chk("beat", cur, q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      prev = cur;
    end
  end

  initial begin
    reset_n = 1'b0;
    done_success = 1'b0;
    done_failure = 1'b0;
    out_ready = 1'b0;
    values = '0;
    load_sol();
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_beat", {out_digit, out_index, out_last, out_fail}, 0);
    reset_n = 1'b1;
    step();
    // 1: full-speed frame, 81 consecutive beats starting one cycle after the flag
    out_ready = 1'b1;
    push_frame();
    done_success = 1'b1;
    for (int i = 0; i < AREA; i++) begin
      step();
      done_success = 1'b0;
      chk("t1_valid", out_valid, 1);
    end
    chk("t1_last", out_last, 1);
    step();
    chk("t1_done", out_valid, 0);
    chk("t1_busy_drain", busy, 1);
    step();
    chk("t1_idle", busy, 0);
    chk("t1_q", q.size(), 0);
    // 2: same frame under random backpressure
    rnd = 1'b1;
    push_frame();
    done_success = 1'b1;
    step();
    done_success = 1'b0;
    drain(2000);
    rnd = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("t2_idle", busy, 0);
    // 3: failure beat, busy until flags drop
    q.push_back({1'b1, 4'd0, 7'd0, 1'b1, 1'b1});
    done_failure = 1'b1;
    drain(20);
    repeat (5) step();
    chk("t3_busy", busy, 1);
    chk("t3_valid", out_valid, 0);
    done_failure = 1'b0;
    step();
    chk("t3_idle", busy, 0);
    // 4: both flags together, then held: exactly one failure beat
    q.push_back({1'b1, 4'd0, 7'd0, 1'b1, 1'b1});
    done_failure = 1'b1;
    done_success = 1'b1;
    drain(20);
    repeat (10) step();
    chk("t4_noframe", out_valid, 0);
    chk("t4_busy", busy, 1);
    done_failure = 1'b0;
    done_success = 1'b0;
    repeat (2) step();
    chk("t4_idle", busy, 0);
    push_frame();
    done_success = 1'b1;
    step();
    done_success = 1'b0;
    drain(200);
    repeat (2) step();
    // 5: asynchronous reset at beat 40, then a fresh frame
    push_frame();
    done_success = 1'b1;
    step();
    done_success = 1'b0;
    for (int n = 0; n < 200 && !(out_valid && out_index == 7'd40); n++) step();
    chk("t5_reach40", out_index, 40);
    #1;
    reset_n = 1'b0;
    q.delete();
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_beat", {out_digit, out_index, out_last, out_fail}, 0);
    chk("t5_rst_busy", busy, 0);
    step();
    reset_n = 1'b1;
    step();
    push_frame();
    done_success = 1'b1;
    step();
    done_success = 1'b0;
    drain(200);
    repeat (2) step();
    // 6: malformed tile 17
    values[17*LEN +: LEN] = 9'b000000101;
`ifdef GRID_READOUT_ONEHOT_CHECK_EN
    expd[17] = 4'd0;
`else
    expd[17] = 4'd1;
`endif
    push_frame();
    done_success = 1'b1;
    step();
    done_success = 1'b0;
    for (int n = 0; n < 200 && !(out_valid && out_index == 7'd17); n++) step();
    chk("t6_pre_err", err, 0);
    drain(200);
    repeat (3) step();
`ifdef GRID_READOUT_ONEHOT_CHECK_EN
    chk("t6_err", err, 1);
`else
    chk("t6_err", err, 0);
`endif
    chk("t6_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
